// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file with
// pending scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;
  // Width that can hold a popcount from 0 up to and including NUM_REGS.
  localparam int DEF_CNT_WIDTH  = DEF_ADDR_WIDTH + 1;

  typedef logic [DEF_ADDR_WIDTH-1:0] sel_t;

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Bus bundle for regfile_2r1w_sb: write port, two read ports with busy
// flags, reservation handshake and the live pending count.
interface regfile_2r1w_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  we;
  logic [ADDR_WIDTH-1:0] wsel;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] rsel_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  busy_a;
  logic [ADDR_WIDTH-1:0] rsel_b;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  busy_b;
  logic                  reserve;
  logic [ADDR_WIDTH-1:0] reserve_sel;
  logic                  reserve_ack;
  logic [ADDR_WIDTH:0]   pending_count;

  modport master (
    output we, wsel, wdata, rsel_a, rsel_b, reserve, reserve_sel,
    input  rdata_a, busy_a, rdata_b, busy_b, reserve_ack, pending_count
  );

  modport slave (
    input  we, wsel, wdata, rsel_a, rsel_b, reserve, reserve_sel,
    output rdata_a, busy_a, rdata_b, busy_b, reserve_ack, pending_count
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, hardwired-zero override,
// same-cycle write forwarding and the matching busy flag.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [NUM_REGS-1:0]                 pending,
  input  logic                                wr_en,    // already qualified by reset and r0
  input  logic [ADDR_WIDTH-1:0]               wr_sel,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic [ADDR_WIDTH-1:0]               rsel,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                busy
);

  logic is_zero;
  logic fwd_hit;

  // Select data and busy for this port; r0 override beats forwarding.
  always_comb begin
    rdata   = regs[rsel];
    busy    = pending[rsel];
    is_zero = (ZERO_REG != 0) && (rsel == {ADDR_WIDTH{1'b0}});
    fwd_hit = (BYPASS != 0) && wr_en && (wr_sel == rsel);
    if (is_zero) begin
      rdata = {DATA_WIDTH{1'b0}};
      busy  = 1'b0;
    end else if (fwd_hit) begin
      // The writeback landing this edge retires the pending producer.
      rdata = wr_data;
      busy  = 1'b0;
    end else begin
      rdata = regs[rsel];
      busy  = pending[rsel];
    end
  end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Parametrised 2-read/1-write register file with optional write-through
// forwarding, optional hardwired-zero r0 and a per-register pending
// scoreboard with a registered pending count.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  regfile_2r1w_sb_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pending_q, pending_d;
  logic [CNT_W-1:0]                    count_q, count_d;

  logic wr_en;
  logic rsv_zero;
  logic rsv_busy;
  logic rsv_ack;
  logic set_en;
  logic clr_en;

  // Qualify write and reservation; the reserve busy check mirrors the read
  // ports so a same-cycle writeback frees the register when forwarding.
  always_comb begin
    wr_en    = bus.we && reset_n &&
               !((ZERO_REG != 0) && (bus.wsel == {ADDR_WIDTH{1'b0}}));
    rsv_zero = (ZERO_REG != 0) && (bus.reserve_sel == {ADDR_WIDTH{1'b0}});
    rsv_busy = pending_q[bus.reserve_sel];
    if (rsv_zero) begin
      rsv_busy = 1'b0;
    end else if ((BYPASS != 0) && wr_en && (bus.wsel == bus.reserve_sel)) begin
      rsv_busy = 1'b0;
    end else begin
      rsv_busy = pending_q[bus.reserve_sel];
    end
    rsv_ack = bus.reserve && reset_n && !rsv_busy;
    // r0 reservations are acknowledged but never recorded.
    set_en  = rsv_ack && !rsv_zero;
    // Only a write that actually retires a pending bit lowers the count.
    clr_en  = wr_en && pending_q[bus.wsel];
  end

  // Next storage and scoreboard state; a set after a clear on the same
  // register lets the new producer win.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en) begin
      regs_d[bus.wsel]    = bus.wdata;
      pending_d[bus.wsel] = 1'b0;
    end else begin
      regs_d    = regs_q;
      pending_d = pending_q;
    end
    if (set_en) begin
      pending_d[bus.reserve_sel] = 1'b1;
    end else begin
      pending_d[bus.reserve_sel] = pending_d[bus.reserve_sel];
    end
  end

  // Incremental popcount of the pending vector.
  always_comb begin
    count_d = count_q;
    case ({set_en, clr_en})
      2'b10:   count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q    <= {(NUM_REGS*DATA_WIDTH){1'b0}};
      pending_q <= {NUM_REGS{1'b0}};
      count_q   <= {CNT_W{1'b0}};
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign bus.reserve_ack   = rsv_ack;
  assign bus.pending_count = count_q;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_port_a (
    .regs    (regs_q),
    .pending (pending_q),
    .wr_en   (wr_en),
    .wr_sel  (bus.wsel),
    .wr_data (bus.wdata),
    .rsel    (bus.rsel_a),
    .rdata   (bus.rdata_a),
    .busy    (bus.busy_a)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_port_b (
    .regs    (regs_q),
    .pending (pending_q),
    .wr_en   (wr_en),
    .wr_sel  (bus.wsel),
    .wr_data (bus.wdata),
    .rsel    (bus.rsel_b),
    .rdata   (bus.rdata_b),
    .busy    (bus.busy_b)
  );

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised successor to the single-port 4x8 register file in the EMU v8 datapath.
- Provides two combinational read ports and one synchronous write port with write enable.
- Adds optional write-through bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard with a live pending count.
- Feeds the ALU operand muxes and the issue/stall logic.

Parameters:
- DATA_WIDTH, 8, width of each register.
- ADDR_WIDTH, 2, select width; NUM_REGS = 2**ADDR_WIDTH.
- ZERO_REG, 0, when 1: register 0 always reads 0, ignores writes, and is never pending.
- BYPASS, 1, when 1: same-cycle write data and write-clear are forwarded to the read ports and busy flags.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- wsel  in  ADDR_WIDTH  write register select
- wdata  in  DATA_WIDTH  write data
- rsel_a  in  ADDR_WIDTH  read port A select
- rdata_a  out  DATA_WIDTH  read port A data
- busy_a  out  1  register rsel_a awaits writeback
- rsel_b  in  ADDR_WIDTH  read port B select
- rdata_b  out  DATA_WIDTH  read port B data
- busy_b  out  1  register rsel_b awaits writeback
- reserve  in  1  request to mark reserve_sel pending
- reserve_sel  in  ADDR_WIDTH  register to reserve
- reserve_ack  out  1  reservation accepted this cycle
- pending_count  out  ADDR_WIDTH+1  number of pending registers (registered)

Behaviour:
- Reset: while reset_n=0, all registers, the pending[] vector, and pending_count are cleared to 0 immediately, not on a clock edge. rdata_a/b then read 0 combinationally; busy_a/b=0; reserve_ack=0.
- A reset asserted mid-operation discards all state. The first edge after release sees a clean file.
- Write: on a rising edge with we=1, regs[wsel] <= wdata and pending[wsel] <= 0. A write to a non-pending register is legal; pending stays 0.
- ZERO_REG=1 and wsel=0: the write is ignored.
- Read: rdata_x = regs[rsel_x], combinational. There is no read latency.
- BYPASS=1 and we=1 and wsel==rsel_x (with wsel!=0 when ZERO_REG=1): rdata_x = wdata.
- ZERO_REG=1 and rsel_x=0: rdata_x = 0, which overrides bypass.
- Busy: busy_x = pending[rsel_x]. When BYPASS=1, a same-cycle write to rsel_x forces busy_x=0.
- Reserve: reserve_ack = reserve & ~busy(reserve_sel), where busy(reserve_sel) uses the same bypass rule as busy_x.
  - On ack, pending[reserve_sel] <= 1 at the edge.
  - Without ack, state is unchanged. A double reservation is refused, never queued.
- Simultaneous write and reserve to the same register: when BYPASS=1 the reserve is acked and pending ends 1 (new producer wins). When BYPASS=0 the reserve is refused and the write clears pending.
- ZERO_REG=1 and reserve_sel=0: reserve_ack=1 and pending stays 0.
- pending_count tracks the popcount of pending[] at the edge: +1 on an effective set, -1 on an effective clear, net 0 when both hit different registers or the same register as above.
  - It never exceeds NUM_REGS and never underflows. A clear of a non-pending register does not decrement.
- Parallel reads of the same register on A and B are independent and always legal.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - the select typedef (logic [ADDR_WIDTH-1:0]);
  - a popcount-width constant.
- One sub-module, regfile_read_port, instantiated twice. It implements the select, ZERO_REG, and bypass mux plus busy generation for one port.
- Storage, the pending vector, and the counter live in the top.

Test Plan:
1. Reset, then hold reset_n=0 with we=1, wsel=1, wdata=8'hAA across an edge -> rdata_a=0 at rsel_a=1; pending_count=0.
2. Write 8'h01 to r1, 8'h02 to r2, 8'h03 to r3 on successive edges. Then set rsel_a=1, rsel_b=3 -> rdata_a=8'h01, rdata_b=8'h03. Setting rsel_b=2 -> 8'h02.
3. Drive rsel_a=2, we=1, wsel=2, wdata=8'h5C before the edge -> rdata_a=8'h5C same cycle when BYPASS=1. With BYPASS=0 it shows 8'h02 until after the edge.
4. Reserve r1 (ack=1), then reserve r1 again -> second ack=0, busy_a=1 at rsel_a=1, pending_count=1. Write r1=8'h77 -> busy_a=0, pending_count=0.
5. Reserve r2 and r3 on consecutive cycles, then in one cycle write r2 and reserve r1 -> pending_count=2, with pending = {r1, r3}. Assert reset_n=0 mid-sequence -> count=0 and busy flags 0 immediately.
6. Run with ZERO_REG=1 and write r0=8'hFF -> rdata_a=0 at rsel_a=0. Reserve r0 -> ack=1, busy_a=0, pending_count unchanged.
